// File: rtl/fpa_normalize_round_if.sv
// Handshake/data bundle for fpa_normalize_round.
//   in_valid/in_ready      : upstream adder-core result handshake
//   in_sign/in_exp/in_mant : raw sum {carry, hidden, fraction, G, R, S}
//   in_nan/in_inf          : special-case results (NaN wins over infinity)
//   out_valid/out_ready    : downstream handshake
//   out_result             : packed {sign, exp, fraction}
//   out_overflow/out_underflow/out_inexact : IEEE flags, qualified by out_valid
// slave is the rounding block's view, master is the producer/consumer side.
interface fpa_normalize_round_if #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
);
  logic                                in_valid;
  logic                                in_ready;
  logic                                in_sign;
  logic [EXP_WIDTH-1:0]                in_exp;
  logic [MANTISSA_WIDTH+4:0]           in_mant;
  logic                                in_nan;
  logic                                in_inf;
  logic                                out_valid;
  logic                                out_ready;
  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   out_result;
  logic                                out_overflow;
  logic                                out_underflow;
  logic                                out_inexact;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fpa_normalize_round.sv
// Two-stage normalize/round back end of a floating-point adder.
//   Stage 1 normalizes the raw sum (carry right-shift or leading-zero
//   left-shift) and classifies special results; stage 2 applies
//   round-to-nearest-even, detects overflow and packs the result.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fpa_normalize_round_if.slave (handshakes, operand, result, flags)
module fpa_normalize_round #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fpa_normalize_round_if.slave    bus
);

  localparam int M   = MANTISSA_WIDTH;
  localparam int XW  = EXP_WIDTH + 2;      // signed exponent width, never wraps
  localparam int NW  = M + 4;              // hidden + fraction + G/R/S
  localparam int LZW = $clog2(NW + 1);
  localparam int RW  = 1 + EXP_WIDTH + M;

  localparam logic [2:0] K_NORM = 3'd0;
  localparam logic [2:0] K_ZERO = 3'd1;
  localparam logic [2:0] K_UFL  = 3'd2;
  localparam logic [2:0] K_INF  = 3'd3;
  localparam logic [2:0] K_NAN  = 3'd4;

  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF = XW'((2**EXP_WIDTH) - 1);

  // ---------------- handshake ----------------
  logic s1_valid_q, s2_valid_q;
  logic s2_load, s1_load;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;

  // ---------------- stage 1: normalize ----------------
  // The hidden bit is implied after normalization, so only
  // fraction + G/R/S (NW-1 bits) are carried into stage 2.
  logic                  s1_sign_q;
  logic signed [XW-1:0]  s1_exp_q, s1_exp_d;
  logic [NW-2:0]         s1_mant_q, s1_mant_d;
  logic [2:0]            s1_kind_q, s1_kind_d;

  logic [LZW-1:0]        lz;
  logic                  found;
  logic signed [XW-1:0]  exp_x, lz_x;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (!found) begin
        if (bus.in_mant[i]) found = 1'b1;
        else                lz    = lz + LZW'(1);
      end
    end
  end

  always_comb begin
    exp_x     = $signed(XW'(bus.in_exp));
    lz_x      = $signed(XW'(lz));
    s1_kind_d = K_NORM;
    s1_exp_d  = exp_x;
    s1_mant_d = bus.in_mant[NW-2:0];
    if (bus.in_nan) begin
      s1_kind_d = K_NAN;
    end else if (bus.in_inf) begin
      s1_kind_d = K_INF;
    end else if (bus.in_mant == '0) begin
      s1_kind_d = K_ZERO;
    end else if (bus.in_mant[NW]) begin
      // carry: shift right one, fold the dropped bit into sticky
      s1_mant_d = {bus.in_mant[NW-1:2], bus.in_mant[1] | bus.in_mant[0]};
      s1_exp_d  = exp_x + ONE_X;
    end else if (!bus.in_mant[NW-1]) begin
      if (exp_x <= lz_x) begin
        s1_kind_d = K_UFL;
      end else begin
        // leading one lands just above the kept bits and is dropped
        s1_mant_d = bus.in_mant[NW-2:0] << lz;
        s1_exp_d  = exp_x - lz_x;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_kind_q  <= K_ZERO;
    end else begin
      if (s1_load) s1_valid_q <= bus.in_valid;
      if (s1_load && bus.in_valid) begin
        s1_sign_q <= bus.in_sign;
        s1_exp_q  <= s1_exp_d;
        s1_mant_q <= s1_mant_d;
        s1_kind_q <= s1_kind_d;
      end
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic [M-1:0]          frac;
  logic                  g_bit, r_bit, s_bit, inc;
  logic [M:0]            frac_sum;
  logic signed [XW-1:0]  exp_r;
  logic [RW-1:0]         res_d, res_q;
  logic                  ov_d, uf_d, inx_d;
  logic                  ov_q, uf_q, inx_q;

  always_comb begin
    frac     = s1_mant_q[NW-2:3];
    g_bit    = s1_mant_q[2];
    r_bit    = s1_mant_q[1];
    s_bit    = s1_mant_q[0];
    inc      = g_bit & (r_bit | s_bit | frac[0]);
    frac_sum = {1'b0, frac} + (M+1)'(inc);
    // carry out of the fraction leaves it all-zero; only the exponent moves
    exp_r    = frac_sum[M] ? (s1_exp_q + ONE_X) : s1_exp_q;
    res_d    = '0;
    ov_d     = 1'b0;
    uf_d     = 1'b0;
    inx_d    = 1'b0;
    case (s1_kind_q)
      K_NAN:  res_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(M-1){1'b0}}};
      K_INF:  res_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
      K_ZERO: res_d = {s1_sign_q, {(EXP_WIDTH+M){1'b0}}};
      K_UFL: begin
        res_d = {s1_sign_q, {(EXP_WIDTH+M){1'b0}}};
        uf_d  = 1'b1;
        inx_d = 1'b1;
      end
      default: begin
        inx_d = g_bit | r_bit | s_bit;
        if (exp_r >= EXP_INF) begin
          res_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
          ov_d  = 1'b1;
          inx_d = 1'b1;
        end else begin
          res_d = {s1_sign_q, exp_r[EXP_WIDTH-1:0], frac_sum[M-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      ov_q       <= 1'b0;
      uf_q       <= 1'b0;
      inx_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q <= res_d;
        ov_q  <= ov_d;
        uf_q  <= uf_d;
        inx_q <= inx_d;
      end
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.out_result    = res_q;
  assign bus.out_overflow  = ov_q;
  assign bus.out_underflow = uf_q;
  assign bus.out_inexact   = inx_q;

endmodule

// File: tb/tb_fpa_normalize_round.sv
// Self-checking bench for fpa_normalize_round (single precision defaults).
module tb_fpa_normalize_round;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fpa_normalize_round_if #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) bus();

  fpa_normalize_round #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {overflow, underflow, inexact, result}
  function automatic logic [34:0] model(input logic s, input logic [7:0] e_in,
                                        input logic [27:0] mant,
                                        input logic nan, input logic inf);
    longint m, sig;
    int     e, p, l, grs;
    logic   inx;
    if (nan)       return {3'b000, 32'h7FC00000};
    if (inf)       return {3'b000, s, 8'hFF, 23'h0};
    if (mant == 0) return {3'b000, s, 31'h0};
    m = mant;
    e = e_in;
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e = e + 1;
    end else begin
      p = 26;
      while (((m >> p) & 1) == 0) p--;
      l = 26 - p;
      if (l > 0) begin
        if (e <= l) return {3'b011, s, 31'h0};
        m = m << l;
        e = e - l;
      end
    end
    grs = int'(m & 7);
    sig = m >> 3;
    if (grs > 4 || (grs == 4 && (sig & 1) == 1)) sig = sig + 1;
    if (sig >= (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    inx = (grs != 0);
    if (e >= 255) return {3'b101, s, 8'hFF, 23'h0};
    return {2'b00, inx, s, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [34:0] outv();
    return {bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_result};
  endfunction

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e,
                       input logic [27:0] m, input logic nan, input logic inf);
    bus.in_valid = v;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    bus.in_nan   = nan;
    bus.in_inf   = inf;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- compare process ----------------
  logic [34:0] exp_q[$];
  logic        stall_q = 1'b0;
  logic [34:0] held_q  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {34'b0, bus.out_valid}, 35'd1);
        check("hold_data", outv(), held_q);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", outv());
        end else begin
          check("result", outv(), exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_nan, bus.in_inf));
      stall_q = bus.out_valid && !bus.out_ready;
      held_q  = outv();
    end
  end

  // ---------------- stimulus ----------------
  logic [27:0] st_m[3];
  logic [7:0]  st_e[3];
  int          k;
  logic [34:0] d_exp;
  logic        seen;

  task automatic drain(input string name);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    check(name, 35'(exp_q.size()), 35'd0);
  endtask

  task automatic rand_input();
    int          c;
    logic [27:0] m;
    logic [7:0]  e;
    logic        nan, inf;
    c   = $urandom_range(0, 9);
    m   = 28'($urandom);
    nan = 1'b0;
    inf = 1'b0;
    case (c)
      0, 1: m = m | 28'h8000000;
      2, 3: m = (m & 28'h3FFFFFF) | 28'h4000000;
      4, 5: m = (m & 28'h3FFFFFF) >> $urandom_range(1, 26);
      6:    m = 28'h7FFFFF8 | (m & 28'h7);
      7:    m = '0;
      8:    begin nan = 1'b1; inf = $urandom_range(0, 1) == 1; end
      default: inf = 1'b1;
    endcase
    case ($urandom_range(0, 3))
      0:       e = 8'($urandom_range(1, 30));
      1:       e = 8'($urandom_range(250, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, e, m, nan, inf);
    bus.out_ready = $urandom_range(0, 9) < 7;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;

    // model pinned to hand-computed values
    check("pin_carry",   model(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0), {3'b000, 32'h40000000});
    check("pin_rne_up",  model(1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0), {3'b001, 32'h3F800002});
    check("pin_lshift",  model(1'b0, 8'd127, 28'h0800000, 1'b0, 1'b0), {3'b000, 32'h3E000000});
    check("pin_ovf",     model(1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0), {3'b101, 32'h7F800000});
    check("pin_nan",     model(1'b1, 8'd3,   28'h1234567, 1'b1, 1'b1), {3'b000, 32'h7FC00000});
    check("pin_uflow",   model(1'b1, 8'd3,   28'h0800000, 1'b0, 1'b0), {3'b011, 32'h80000000});
    check("pin_tie_even",model(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0), {3'b001, 32'h3F800000});
    check("pin_rnd_carry",model(1'b0,8'd127, 28'h7FFFFFC, 1'b0, 1'b0), {3'b001, 32'h40000000});

    // asynchronous reset, no clock edge yet
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", outv(), 35'd0);
    check("rst_handshake", {33'b0, bus.out_valid, bus.in_ready}, 35'b01);
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // carry case with explicit latency
    drive(1'b1, 1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("lat_after_1", {34'b0, bus.out_valid}, 35'd0);
    step();
    check("lat_after_2", {34'b0, bus.out_valid}, 35'd1);
    check("lat_value", outv(), {3'b000, 32'h40000000});
    step();

    // directed cases back to back
    drive(1'b1, 1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'd127, 28'h0800000, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0); step();
    drive(1'b1, 1'b1, 8'd5,   28'h0000000, 1'b1, 1'b0); step();
    drive(1'b1, 1'b1, 8'd5,   28'h0000000, 1'b0, 1'b1); step();
    drive(1'b1, 1'b1, 8'd9,   28'h0000000, 1'b0, 1'b0); step();
    drive(1'b1, 1'b0, 8'd2,   28'h0000100, 1'b0, 1'b0); step();
    drain("drain_directed");

    // stall: three inputs offered while the output is blocked
    st_m[0] = 28'h4000001; st_e[0] = 8'd100;
    st_m[1] = 28'h8000003; st_e[1] = 8'd101;
    st_m[2] = 28'h0012345; st_e[2] = 8'd102;
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (k < 3) drive(1'b1, 1'b0, st_e[k], st_m[k], 1'b0, 1'b0);
      else       bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) k++;
      step();
    end
    check("stall_accepted", 35'(k), 35'd2);
    check("stall_in_ready", {34'b0, bus.in_ready}, 35'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      drive(1'b1, 1'b0, st_e[k], st_m[k], 1'b0, 1'b0);
      @(negedge clk);
      if (bus.in_ready) k++;
      step();
    end
    check("stall_third_accepted", 35'(k), 35'd3);
    drain("drain_stall");

    // reset with both stages full
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      drive(1'b1, 1'b0, 8'd120, 28'h4000000 | 28'(c), 1'b0, 1'b0);
      @(negedge clk);
      if (bus.in_ready) k++;
      step();
    end
    bus.in_valid = 1'b0;
    check("full_before_reset", {33'b0, bus.out_valid, bus.in_ready}, 35'b10);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", outv(), 35'd0);
    check("midreset_handshake", {33'b0, bus.out_valid, bus.in_ready}, 35'b01);
    step();
    step();
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_stale", {34'b0, bus.out_valid}, 35'd0);
    end
    step();
    drive(1'b1, 1'b1, 8'd77, 28'h5ABCDE7, 1'b0, 1'b0);
    d_exp = model(1'b1, 8'd77, 28'h5ABCDE7, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        check("first_after_reset", outv(), d_exp);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL first_after_reset: got no output expected %h", d_exp);
    end
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_input();
      step();
    end
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpa_normalize_round.md
FPA_NORMALIZE_ROUND -- requirements
Module: fpa_normalize_round

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored fraction width (M below).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream adder-core result valid.
REQ-006 SHALL have port in_ready  output  1  block can accept input this cycle.
REQ-007 SHALL have port in_sign  input  1  result sign.
REQ-008 SHALL have port in_exp  input  EXP_WIDTH  biased exponent of larger operand.
REQ-009 SHALL have port in_mant  input  M+5  raw sum: [M+4]=carry, [M+3]=hidden, [M+2:3]=fraction, [2]=guard, [1]=round, [0]=sticky.
REQ-010 SHALL have port in_nan  input  1  special-case NaN result.
REQ-011 SHALL have port in_inf  input  1  special-case infinity result (ignored when in_nan=1).
REQ-012 SHALL have port out_valid  output  1  out_result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_result.
REQ-014 SHALL have port out_result  output  1+EXP_WIDTH+M  packed {sign, exp, fraction}.
REQ-015 SHALL have ports out_overflow, out_underflow, out_inexact  output  1 each  IEEE flags, qualified by out_valid.

Function
REQ-016 SHALL be a 2-stage pipeline: stage 1 normalizes, stage 2 rounds and packs; latency 2 cycles from accepted input to out_valid without stall.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Each stage register SHALL load when empty or when the stage after it transfers in the same cycle; otherwise hold its contents unchanged.
REQ-019 in_ready SHALL equal !s1_valid || (s2 loads this cycle); full throughput of 1 result/cycle when out_ready=1.
REQ-020 out_result and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Carry=1: mantissa SHALL shift right 1, shifted-out bit ORed into sticky, exponent+1.
REQ-022 Carry=0, hidden=0, mantissa nonzero: SHALL shift left by leading-zero count L of in_mant[M+3:0], exponent-L.
REQ-023 If in_exp <= L (denormal range): result SHALL flush to signed zero, out_underflow=1, out_inexact=1.
REQ-024 Mantissa all zero: result SHALL be exact zero with in_sign, exponent 0, no flags.
REQ-025 Rounding SHALL be round-to-nearest-even: increment fraction when G && (R || S || LSB).
REQ-026 Rounding carry out of fraction SHALL set fraction 0 and exponent+1.
REQ-027 Final exponent >= 2^EXP_WIDTH-1 SHALL produce signed infinity, out_overflow=1, out_inexact=1.
REQ-028 out_inexact SHALL be G|R|S after normalization, or set per REQ-023/REQ-027.
REQ-029 in_nan=1 SHALL produce quiet NaN 0x7FC00000 (sign 0, fraction MSB 1) with no flags; in_inf=1 SHALL produce {in_sign, all-ones, 0} with no flags.
REQ-030 Exponent arithmetic SHALL use EXP_WIDTH+2 signed internal width so no intermediate wraps.

Reset
REQ-031 While rst_n=0: both stage valids, out_valid, out_result, and all flags SHALL be 0 immediately (asynchronous), in_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results; first accepted input after release SHALL be the first output.

Verification
REQ-033 in_exp=127, in_mant carry=1, rest 0 -> out_result 0x40000000, flags 0, 2 cycles later.
REQ-034 in_exp=127, hidden=1, fraction=0x000001, G=1 R=0 S=0 -> 0x3F800002, out_inexact=1.
REQ-035 in_exp=127, hidden=0, only fraction bit 20 set -> 0x3E000000, flags 0.
REQ-036 in_exp=254, carry=1 -> 0x7F800000, out_overflow=1, out_inexact=1; in_nan=1 -> 0x7FC00000.
REQ-037 out_ready=0 for 5 cycles with 3 back-to-back inputs offered -> exactly 2 accepted, in_ready=0 thereafter; after out_ready=1 results emerge in order, third input accepted.
REQ-038 Both stages full, rst_n pulsed low mid-cycle -> out_valid=0 at once, in_ready=1; no stale result after release.
